// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and assembly stage.
// It streams bytes from a synchronous ROM into a small prefetch FIFO. Each byte in the
// FIFO carries its own address. The stage then assembles one-byte instructions (opcode
// MSB clear) or two-byte instructions (opcode MSB set, followed by an immediate byte).
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   mem_addr, mem_rd  ROM address (the fetch pointer) and read strobe
//   mem_data          ROM byte, valid the cycle after a read is sampled
//   instr_*           assembled instruction, valid/ready handshake to decode
//   redirect(_addr)   flush the pipe and restart fetching at a new address
module fetch_unit #(
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_op,
  output logic [DATA_W-1:0] instr_imm,
  output logic              instr_len2,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr
);

  localparam int unsigned     PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned     CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_inflight_addr;
  logic              r_inflight;
  logic              r_discard;
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_idx;
  logic [PTR_W-1:0]  r_rd_idx;
  logic [CNT_W-1:0]  r_count;

  logic              r_valid;
  logic [DATA_W-1:0] r_op;
  logic [DATA_W-1:0] r_imm;
  logic              r_len2;
  logic [ADDR_W-1:0] r_pc;

  logic              w_issue;
  logic              w_push;
  logic              w_head_len2;
  logic              w_take;
  logic              w_load;
  logic [CNT_W:0]    w_occupancy;
  logic [PTR_W-1:0]  w_next_idx;
  logic [DATA_W-1:0] w_head_data;
  logic [DATA_W-1:0] w_second_data;
  logic [CNT_W-1:0]  w_pop_n;

  always_comb begin
    // The in-flight byte already owns a FIFO slot, so overflow is impossible.
    w_occupancy   = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    w_issue       = !rst && (w_occupancy < DEPTH_C);
    w_push        = r_inflight && !r_discard;
    w_head_data   = r_fifo_data[r_rd_idx];
    w_next_idx    = r_rd_idx + PTR_W'(1);
    w_second_data = r_fifo_data[w_next_idx];
    w_head_len2   = w_head_data[DATA_W-1];
    // A two-byte opcode waits until its immediate is also buffered.
    w_take        = (r_count != '0) && (!w_head_len2 || (r_count >= CNT_W'(2)));
    w_load        = (!r_valid || instr_ready) && w_take;
    w_pop_n       = !w_load ? '0 : (w_head_len2 ? CNT_W'(2) : CNT_W'(1));
  end

  // FIFO storage needs no reset: the count and indices decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push && !redirect) begin
      r_fifo_data[r_wr_idx] <= mem_data;
      r_fifo_addr[r_wr_idx] <= r_inflight_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr           <= RESET_ADDR;
      r_inflight_addr <= '0;
      r_inflight      <= 1'b0;
      r_discard       <= 1'b0;
      r_wr_idx        <= '0;
      r_rd_idx        <= '0;
      r_count         <= '0;
      r_valid         <= 1'b0;
      r_op            <= '0;
      r_imm           <= '0;
      r_len2          <= 1'b0;
      r_pc            <= '0;
    end else if (redirect) begin
      // A read issued on this edge returns a stale byte next cycle; drop it then.
      r_ptr      <= redirect_addr;
      r_inflight <= w_issue;
      r_discard  <= w_issue;
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
    end else begin
      if (w_issue) begin
        r_ptr <= r_ptr + ADDR_W'(1);
      end
      r_inflight      <= w_issue;
      r_inflight_addr <= r_ptr;
      r_discard       <= 1'b0;
      if (w_push) begin
        r_wr_idx <= r_wr_idx + PTR_W'(1);
      end
      r_rd_idx <= r_rd_idx + PTR_W'(w_pop_n);
      r_count  <= r_count + CNT_W'(w_push) - w_pop_n;
      if (w_load) begin
        r_valid <= 1'b1;
        r_op    <= w_head_data;
        r_imm   <= w_head_len2 ? w_second_data : '0;
        r_len2  <= w_head_len2;
        r_pc    <= r_fifo_addr[r_rd_idx];
      end else if (instr_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign mem_addr    = r_ptr;
  assign mem_rd      = w_issue;
  assign instr_valid = r_valid;
  assign instr_op    = r_op;
  assign instr_imm   = r_imm;
  assign instr_len2  = r_len2;
  assign instr_pc    = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  imm;
    logic        len2;
    logic [15:0] pc;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst;
  bit   [7:0]  rom [0:65535];

  logic [15:0] a_mem_addr, a_pc, a_redirect_addr;
  logic [7:0]  a_mem_data, a_op, a_imm;
  logic        a_mem_rd, a_valid, a_ready, a_len2, a_redirect;
  logic [15:0] b_mem_addr, b_pc, b_redirect_addr;
  logic [7:0]  b_mem_data, b_op, b_imm;
  logic        b_mem_rd, b_valid, b_ready, b_len2, b_redirect;

  instr_t exp_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(DEPTH), .RESET_ADDR(16'h0000)) dut_a (
    .clk(clk), .rst(rst), .mem_addr(a_mem_addr), .mem_rd(a_mem_rd), .mem_data(a_mem_data),
    .instr_valid(a_valid), .instr_ready(a_ready), .instr_op(a_op), .instr_imm(a_imm),
    .instr_len2(a_len2), .instr_pc(a_pc), .redirect(a_redirect), .redirect_addr(a_redirect_addr)
  );

  fetch_unit #(.ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(DEPTH), .RESET_ADDR(16'hFFFF)) dut_b (
    .clk(clk), .rst(rst), .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .mem_data(b_mem_data),
    .instr_valid(b_valid), .instr_ready(b_ready), .instr_op(b_op), .instr_imm(b_imm),
    .instr_len2(b_len2), .instr_pc(b_pc), .redirect(b_redirect), .redirect_addr(b_redirect_addr)
  );

  // Synchronous ROM shared by both instances.
  always @(posedge clk) begin
    a_mem_data <= rom[a_mem_addr];
    b_mem_data <= rom[b_mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Decode the ROM image from start and queue the instructions decode should receive.
  task automatic push_prog(input logic [15:0] start, input int n);
    logic [15:0] pc;
    logic [15:0] nxt;
    instr_t      e;
    pc = start;
    for (int i = 0; i < n; i++) begin
      nxt    = pc + 16'd1;
      e.op   = rom[pc];
      e.pc   = pc;
      e.len2 = e.op[7];
      e.imm  = e.op[7] ? rom[nxt] : 8'h00;
      pc     = e.op[7] ? pc + 16'd2 : nxt;
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard: every transfer seen on DUT A is matched against the queue head.
  always @(negedge clk) begin
    if (!rst && a_valid && a_ready) begin
      check_eq("instr_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        instr_t e;
        e = exp_q.pop_front();
        check_eq("sb_op", 32'(a_op), 32'(e.op));
        check_eq("sb_imm", 32'(a_imm), 32'(e.imm));
        check_eq("sb_len2", 32'(a_len2), 32'(e.len2));
        check_eq("sb_pc", 32'(a_pc), 32'(e.pc));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    a_ready = 1'b0;
    b_ready = 1'b0;
    exp_q.delete();
    rom = '{default: 8'h00};
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    rst = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input bit use_b, input int max, input string tag);
    int n;
    n = 0;
    while (!(use_b ? b_valid : a_valid) && n < max) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(use_b ? b_valid : a_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_ready = 1'b0; a_redirect = 1'b0; a_redirect_addr = '0;
    b_ready = 1'b0; b_redirect = 1'b0; b_redirect_addr = '0;
    #2;
    check_eq("rst_valid", 32'(a_valid), 32'd0);
    check_eq("rst_mem_rd", 32'(a_mem_rd), 32'd0);
    check_eq("rst_op", 32'(a_op), 32'd0);
    check_eq("rst_imm", 32'(a_imm), 32'd0);
    check_eq("rst_len2", 32'(a_len2), 32'd0);
    check_eq("rst_pc", 32'(a_pc), 32'd0);
    check_eq("rst_addr_a", 32'(a_mem_addr), 32'h0000);
    check_eq("rst_addr_b", 32'(b_mem_addr), 32'hFFFF);

    // One-byte instructions back to back; first valid after the third edge.
    do_reset();
    rom[0] = 8'h00; rom[1] = 8'h10; rom[2] = 8'h05;
    push_prog(16'h0000, 40);
    a_ready = 1'b1;
    release_reset();
    check_eq("t1_mem_rd", 32'(a_mem_rd), 32'd1);
    tick();
    check_eq("t1_valid_e0", 32'(a_valid), 32'd0);
    check_eq("t1_addr_e0", 32'(a_mem_addr), 32'h0001);
    tick();
    check_eq("t1_valid_e1", 32'(a_valid), 32'd0);
    tick();
    check_eq("t1_valid_e2", 32'(a_valid), 32'd1);
    check_eq("t1_pc_e2", 32'(a_pc), 32'h0000);
    tick();
    check_eq("t1_pc_e3", 32'(a_pc), 32'h0001);
    check_eq("t1_op_e3", 32'(a_op), 32'h10);
    tick();
    check_eq("t1_pc_e4", 32'(a_pc), 32'h0002);
    check_eq("t1_op_e4", 32'(a_op), 32'h05);
    repeat (3) tick();

    // Two-byte instruction followed by a one-byte one.
    do_reset();
    rom[0] = 8'h85; rom[1] = 8'h3C; rom[2] = 8'h11;
    push_prog(16'h0000, 40);
    a_ready = 1'b1;
    release_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("t2_valid_e%0d", i), 32'(a_valid), 32'd0);
    end
    tick();
    check_eq("t2_valid_e3", 32'(a_valid), 32'd1);
    check_eq("t2_op", 32'(a_op), 32'h85);
    check_eq("t2_imm", 32'(a_imm), 32'h3C);
    tick();
    check_eq("t2_next_pc", 32'(a_pc), 32'h0002);
    repeat (3) tick();

    // Backpressure: output holds, FIFO fills, reads stop; release drains in order.
    do_reset();
    for (int i = 0; i < 40; i++) rom[i] = 8'(i + 1);
    push_prog(16'h0000, 60);
    release_reset();
    repeat (3) tick();
    for (int i = 3; i < 10; i++) begin
      check_eq($sformatf("t3_hold_op_%0d", i), 32'(a_op), 32'h01);
      tick();
    end
    check_eq("t3_valid", 32'(a_valid), 32'd1);
    check_eq("t3_pc", 32'(a_pc), 32'h0000);
    check_eq("t3_mem_rd", 32'(a_mem_rd), 32'd0);
    check_eq("t3_count", 32'(dut_a.r_count), 32'(DEPTH));
    check_eq("t3_addr", 32'(a_mem_addr), 32'(DEPTH + 1));
    a_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_eq($sformatf("t3_b2b_pc_%0d", k), 32'(a_pc), 32'(k));
    end

    // Redirect while a read is in flight and an instruction is valid.
    do_reset();
    for (int i = 0; i < 48; i++) rom[i] = 8'(i + 1);
    rom[16'h40] = 8'h85; rom[16'h41] = 8'h3C; rom[16'h42] = 8'h22; rom[16'h43] = 8'h23;
    rom[16'h44] = 8'h24;
    push_prog(16'h0000, 40);
    a_ready = 1'b1;
    release_reset();
    repeat (5) tick();
    check_eq("t4_pre_valid", 32'(a_valid), 32'd1);
    check_eq("t4_pre_rd", 32'(a_mem_rd), 32'd1);
    a_redirect = 1'b1;
    a_redirect_addr = 16'h0040;
    tick();
    a_redirect = 1'b0;
    exp_q.delete();
    push_prog(16'h0040, 20);
    check_eq("t4_valid_cleared", 32'(a_valid), 32'd0);
    check_eq("t4_addr", 32'(a_mem_addr), 32'h0040);
    check_eq("t4_rd", 32'(a_mem_rd), 32'd1);
    wait_valid(1'b0, 10, "t4_valid_timeout");
    check_eq("t4_first_pc", 32'(a_pc), 32'h0040);
    check_eq("t4_first_op", 32'(a_op), 32'h85);
    repeat (4) tick();

    // Instance B: two-byte instruction straddling the address wrap.
    do_reset();
    rom[16'hFFFF] = 8'h9A; rom[16'h0000] = 8'h77; rom[16'h0001] = 8'h05;
    release_reset();
    wait_valid(1'b1, 10, "t5_valid_timeout");
    check_eq("t5_op", 32'(b_op), 32'h9A);
    check_eq("t5_imm", 32'(b_imm), 32'h77);
    check_eq("t5_len2", 32'(b_len2), 32'd1);
    check_eq("t5_pc", 32'(b_pc), 32'hFFFF);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check_eq("t5_next_valid", 32'(b_valid), 32'd1);
    check_eq("t5_next_pc", 32'(b_pc), 32'h0001);
    check_eq("t5_next_op", 32'(b_op), 32'h05);

    // Asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 48; i++) rom[i] = 8'(i + 1);
    push_prog(16'h0000, 40);
    a_ready = 1'b1;
    release_reset();
    repeat (6) tick();
    #1;
    rst = 1'b1;
    #1;
    check_eq("t6_valid_async", 32'(a_valid), 32'd0);
    check_eq("t6_rd_async", 32'(a_mem_rd), 32'd0);
    check_eq("t6_addr_async", 32'(a_mem_addr), 32'h0000);
    exp_q.delete();
    push_prog(16'h0000, 40);
    tick();
    release_reset();
    check_eq("t6_restart_rd", 32'(a_mem_rd), 32'd1);
    check_eq("t6_restart_addr", 32'(a_mem_addr), 32'h0000);
    wait_valid(1'b0, 10, "t6_valid_timeout");
    check_eq("t6_first_pc", 32'(a_pc), 32'h0000);
    repeat (4) tick();
    a_ready = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
